// File: rtl/ahb_master_arb_pkg.sv
// Shared types and encodings for the two-master AHB-Lite arbiter.
// Master index, HTRANS encodings, grant states and the per-master hold record.
package ahb_master_arb_pkg;

  typedef logic master_idx_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
  } hold_rec_t;

  localparam int HOLD_W = $bits(hold_rec_t);

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_state_e;

  // A transfer is requested whenever HTRANS carries the NONSEQ bit.
  function automatic logic is_request(input logic [1:0] htrans);
    return (htrans & HTRANS_NONSEQ) != HTRANS_IDLE;
  endfunction

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-master completion tracking: captures a finished data phase while the
// master is stalled behind the other master's address, and replays it later.
module ahb_arb_hold
  import ahb_master_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_ready,
  input  logic        dvalid,
  input  logic        data_owner,
  input  logic        req,
  input  logic        granted,
  input  logic [31:0] bus_rdata,
  input  logic        bus_resp,
  output logic        ready_m,
  output logic [31:0] rdata_m,
  output logic        resp_m
);

  logic             done_reg;
  logic             done_next;
  hold_rec_t        hold_reg;
  hold_rec_t        hold_next;
  logic [HOLD_W-1:0] hold_bits;
  logic             capture;

  assign hold_bits = {bus_rdata, bus_resp};
  // Data phase ends while the master's next address is still waiting for grant.
  assign capture   = bus_ready && dvalid && data_owner && req && !granted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
      hold_reg <= '0;
    end else begin
      done_reg <= done_next;
      hold_reg <= hold_next;
    end
  end

  always_comb begin
    done_next = done_reg;
    hold_next = hold_reg;
    if (capture) begin
      done_next = 1'b1;
      hold_next = hold_rec_t'(hold_bits);
    end else if (granted && bus_ready) begin
      done_next = 1'b0;
    end
  end

  always_comb begin
    ready_m = 1'b1;
    if (done_reg && !granted) begin
      ready_m = 1'b0;
    end else if (done_reg) begin
      ready_m = bus_ready;
    end else if (dvalid && data_owner && req && !granted) begin
      ready_m = 1'b0;
    end else if (dvalid && data_owner) begin
      ready_m = bus_ready;
    end else if (req && !granted) begin
      ready_m = 1'b0;
    end else if (granted) begin
      ready_m = bus_ready;
    end
  end

  assign rdata_m = done_reg ? hold_reg.rdata : bus_rdata;
  assign resp_m  = done_reg ? hold_reg.resp  : bus_resp;

endmodule

// File: rtl/ahb_master_arb.sv
// Two-master AHB-Lite arbiter for single transfers: registered grant selects
// the address mux, data-phase owner selects HWDATA and response routing.
module ahb_master_arb
  import ahb_master_arb_pkg::*;
#(
  parameter int PARK_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [1:0]  HTRANS_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic        HWRITE_M0,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M0,
  input  logic [2:0]  HSIZE_M1,
  input  logic [31:0] HWDATA_M0,
  input  logic [31:0] HWDATA_M1,
  output logic [31:0] HRDATA_M0,
  output logic [31:0] HRDATA_M1,
  output logic        HREADY_M0,
  output logic        HREADY_M1,
  output logic        HRESP_M0,
  output logic        HRESP_M1,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        HMASTER
);

  localparam grant_state_e PARK_STATE = (PARK_MASTER == 0) ? GNT_M0 : GNT_M1;

  logic [31:0] haddr_m  [2];
  logic [1:0]  htrans_m [2];
  logic        hwrite_m [2];
  logic [2:0]  hsize_m  [2];
  logic [31:0] hwdata_m [2];
  logic [31:0] rdata_m  [2];
  logic        ready_m  [2];
  logic        resp_m   [2];
  logic [1:0]  req;

  grant_state_e grant_reg;
  grant_state_e grant_next;
  logic         dvalid_reg;
  logic         dvalid_next;
  master_idx_t  downer_reg;
  master_idx_t  downer_next;
  master_idx_t  grant;

  assign haddr_m[0]  = HADDR_M0;
  assign haddr_m[1]  = HADDR_M1;
  assign htrans_m[0] = HTRANS_M0;
  assign htrans_m[1] = HTRANS_M1;
  assign hwrite_m[0] = HWRITE_M0;
  assign hwrite_m[1] = HWRITE_M1;
  assign hsize_m[0]  = HSIZE_M0;
  assign hsize_m[1]  = HSIZE_M1;
  assign hwdata_m[0] = HWDATA_M0;
  assign hwdata_m[1] = HWDATA_M1;

  assign grant = master_idx_t'(grant_reg);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_reg  <= PARK_STATE;
      dvalid_reg <= 1'b0;
      downer_reg <= 1'b0;
    end else begin
      grant_reg  <= grant_next;
      dvalid_reg <= dvalid_next;
      downer_reg <= downer_next;
    end
  end

  // Grant hands over whenever the other master wants the bus, so two
  // continuous requesters alternate transfer by transfer.
  always_comb begin
    grant_next  = grant_reg;
    dvalid_next = dvalid_reg;
    downer_next = downer_reg;
    if (HREADY) begin
      dvalid_next = is_request(HTRANS);
      downer_next = grant;
      case (grant_reg)
        GNT_M0:  if (req[1]) grant_next = GNT_M1;
        GNT_M1:  if (req[0]) grant_next = GNT_M0;
        default: grant_next = PARK_STATE;
      endcase
    end
  end

  assign HADDR   = haddr_m[grant];
  assign HTRANS  = htrans_m[grant];
  assign HWRITE  = hwrite_m[grant];
  assign HSIZE   = hsize_m[grant];
  assign HWDATA  = hwdata_m[downer_reg];
  assign HMASTER = grant;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign req[gi] = is_request(htrans_m[gi]);

    ahb_arb_hold u_hold (
      .clk        (HCLK),
      .rst_n      (HRESETn),
      .bus_ready  (HREADY),
      .dvalid     (dvalid_reg),
      .data_owner (downer_reg == master_idx_t'(gi)),
      .req        (req[gi]),
      .granted    (grant == master_idx_t'(gi)),
      .bus_rdata  (HRDATA),
      .bus_resp   (HRESP),
      .ready_m    (ready_m[gi]),
      .rdata_m    (rdata_m[gi]),
      .resp_m     (resp_m[gi])
    );
  end

  assign HRDATA_M0 = rdata_m[0];
  assign HRDATA_M1 = rdata_m[1];
  assign HREADY_M0 = ready_m[0];
  assign HREADY_M1 = ready_m[1];
  assign HRESP_M0  = resp_m[0];
  assign HRESP_M1  = resp_m[1];

endmodule

// File: tb/tb_ahb_master_arb.sv
// Directed bench for ahb_master_arb: the bench plays both masters and the
// slave side cycle by cycle and checks hand-derived values.
module tb_ahb_master_arb;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR_M0, HADDR_M1;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic        HWRITE_M0, HWRITE_M1;
  logic [2:0]  HSIZE_M0, HSIZE_M1;
  logic [31:0] HWDATA_M0, HWDATA_M1;
  logic [31:0] HRDATA_M0, HRDATA_M1;
  logic        HREADY_M0, HREADY_M1;
  logic        HRESP_M0, HRESP_M1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        HMASTER;

  int errors;
  int checks;

  ahb_master_arb #(.PARK_MASTER(0)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR_M0  (HADDR_M0),
    .HADDR_M1  (HADDR_M1),
    .HTRANS_M0 (HTRANS_M0),
    .HTRANS_M1 (HTRANS_M1),
    .HWRITE_M0 (HWRITE_M0),
    .HWRITE_M1 (HWRITE_M1),
    .HSIZE_M0  (HSIZE_M0),
    .HSIZE_M1  (HSIZE_M1),
    .HWDATA_M0 (HWDATA_M0),
    .HWDATA_M1 (HWDATA_M1),
    .HRDATA_M0 (HRDATA_M0),
    .HRDATA_M1 (HRDATA_M1),
    .HREADY_M0 (HREADY_M0),
    .HREADY_M1 (HREADY_M1),
    .HRESP_M0  (HRESP_M0),
    .HRESP_M1  (HRESP_M1),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HMASTER   (HMASTER)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0(input logic [1:0] tr, input logic [31:0] a, input logic w);
    HTRANS_M0 = tr;
    HADDR_M0  = a;
    HWRITE_M0 = w;
  endtask

  task automatic m1(input logic [1:0] tr, input logic [31:0] a, input logic w);
    HTRANS_M1 = tr;
    HADDR_M1  = a;
    HWRITE_M1 = w;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    HRESETn   = 1'b0;
    HSIZE_M0  = 3'b010;
    HSIZE_M1  = 3'b010;
    HWDATA_M0 = 32'h0;
    HWDATA_M1 = 32'h0;
    m0(2'b00, 32'h0, 1'b0);
    m1(2'b00, 32'h0, 1'b0);
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0BAD0BAD;

    // Reset state
    #2;
    chk("rst_hmaster", HMASTER, 32'd0);
    chk("rst_htrans", HTRANS, 32'd0);
    chk("rst_hready_m0", HREADY_M0, 32'd1);
    chk("rst_hready_m1", HREADY_M1, 32'd1);
    chk("rst_hrdata_m1", HRDATA_M1, 32'h0BAD0BAD);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();

    // M0 alone reads repeatedly: no stalls, grant stays on M0
    m0(2'b10, 32'h20000000, 1'b0);
    #1;
    chk("a1_haddr", HADDR, 32'h20000000);
    chk("a1_htrans", HTRANS, 32'h2);
    chk("a1_hmaster", HMASTER, 32'd0);
    chk("a1_hready_m0", HREADY_M0, 32'd1);
    chk("a1_hready_m1", HREADY_M1, 32'd1);
    step();
    HRDATA = 32'h11110001;
    #1;
    chk("a2_hready_m0", HREADY_M0, 32'd1);
    chk("a2_hrdata_m0", HRDATA_M0, 32'h11110001);
    chk("a2_hmaster", HMASTER, 32'd0);
    step();
    m0(2'b00, 32'h0, 1'b0);
    HRDATA = 32'h11110002;
    #1;
    chk("a3_hready_m0", HREADY_M0, 32'd1);
    chk("a3_hrdata_m0", HRDATA_M0, 32'h11110002);
    chk("a3_hready_m1", HREADY_M1, 32'd1);
    step();

    // M1 lone write while grant is parked on M0: one stall cycle
    m1(2'b10, 32'h50000000, 1'b1);
    #1;
    chk("b1_hready_m1", HREADY_M1, 32'd0);
    chk("b1_hmaster", HMASTER, 32'd0);
    chk("b1_htrans", HTRANS, 32'd0);
    chk("b1_hready_m0", HREADY_M0, 32'd1);
    step();
    #1;
    chk("b2_hmaster", HMASTER, 32'd1);
    chk("b2_haddr", HADDR, 32'h50000000);
    chk("b2_hwrite", HWRITE, 32'd1);
    chk("b2_htrans", HTRANS, 32'h2);
    chk("b2_hready_m1", HREADY_M1, 32'd1);
    step();
    m1(2'b00, 32'h0, 1'b0);
    HWDATA_M1 = 32'h000000A5;
    HWDATA_M0 = 32'h0000DEAD;
    #1;
    chk("b3_hwdata", HWDATA, 32'h000000A5);
    chk("b3_hready_m1", HREADY_M1, 32'd1);
    chk("b3_hmaster", HMASTER, 32'd1);
    step();

    // Both masters back-to-back: alternation and held read data
    m0(2'b10, 32'h00000010, 1'b0);
    m1(2'b10, 32'h20000004, 1'b0);
    #1;
    chk("c1_haddr", HADDR, 32'h20000004);
    chk("c1_hready_m0", HREADY_M0, 32'd0);
    chk("c1_hready_m1", HREADY_M1, 32'd1);
    step();
    HRDATA = 32'hB1B1B1B1;
    HRESP  = 1'b1;
    #1;
    chk("c2_haddr", HADDR, 32'h00000010);
    chk("c2_hmaster", HMASTER, 32'd0);
    chk("c2_hready_m0", HREADY_M0, 32'd1);
    chk("c2_hready_m1", HREADY_M1, 32'd0);
    step();
    HRDATA = 32'h12345678;
    HRESP  = 1'b0;
    #1;
    chk("c3_haddr", HADDR, 32'h20000004);
    chk("c3_hmaster", HMASTER, 32'd1);
    chk("c3_hready_m1", HREADY_M1, 32'd1);
    chk("c3_hrdata_m1", HRDATA_M1, 32'hB1B1B1B1);
    chk("c3_hresp_m1", HRESP_M1, 32'd1);
    chk("c3_hready_m0", HREADY_M0, 32'd0);
    step();
    HRDATA = 32'hB2B2B2B2;
    #1;
    chk("c4_hmaster", HMASTER, 32'd0);
    chk("c4_hready_m0", HREADY_M0, 32'd1);
    chk("c4_hrdata_m0", HRDATA_M0, 32'h12345678);
    chk("c4_hresp_m0", HRESP_M0, 32'd0);
    chk("c4_hready_m1", HREADY_M1, 32'd0);
    step();
    m0(2'b00, 32'h0, 1'b0);
    HRDATA = 32'hA1A1A1A1;
    #1;
    chk("c5_hmaster", HMASTER, 32'd1);
    chk("c5_hready_m0", HREADY_M0, 32'd1);
    chk("c5_hrdata_m0", HRDATA_M0, 32'hA1A1A1A1);
    chk("c5_hready_m1", HREADY_M1, 32'd1);
    chk("c5_hrdata_m1", HRDATA_M1, 32'hB2B2B2B2);
    step();

    // Three slave wait states during M1's data phase
    m1(2'b10, 32'h20000008, 1'b0);
    HREADY = 1'b0;
    #1;
    chk("d1_hmaster", HMASTER, 32'd1);
    chk("d1_haddr", HADDR, 32'h20000008);
    chk("d1_hready_m1", HREADY_M1, 32'd0);
    chk("d1_hready_m0", HREADY_M0, 32'd1);
    step();
    #1;
    chk("d2_hmaster", HMASTER, 32'd1);
    chk("d2_hready_m1", HREADY_M1, 32'd0);
    step();
    #1;
    chk("d3_haddr", HADDR, 32'h20000008);
    chk("d3_hready_m1", HREADY_M1, 32'd0);
    step();
    HREADY = 1'b1;
    HRDATA = 32'hC3C3C3C3;
    #1;
    chk("d4_hready_m1", HREADY_M1, 32'd1);
    chk("d4_hrdata_m1", HRDATA_M1, 32'hC3C3C3C3);
    chk("d4_hmaster", HMASTER, 32'd1);
    step();

    // Asynchronous reset in the middle of M1's data phase
    m1(2'b00, 32'h0, 1'b0);
    HREADY    = 1'b0;
    HWDATA_M0 = 32'h0000BEEF;
    HWDATA_M1 = 32'h0000F00D;
    #1;
    chk("e1_hmaster", HMASTER, 32'd1);
    chk("e1_hwdata", HWDATA, 32'h0000F00D);
    chk("e1_hready_m1", HREADY_M1, 32'd0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("e2_hmaster", HMASTER, 32'd0);
    chk("e2_hwdata", HWDATA, 32'h0000BEEF);
    chk("e2_hready_m1", HREADY_M1, 32'd1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    m0(2'b10, 32'h00000040, 1'b0);
    m1(2'b10, 32'h00000044, 1'b0);
    #1;
    chk("e3_hmaster", HMASTER, 32'd0);
    chk("e3_haddr", HADDR, 32'h00000040);
    chk("e3_htrans", HTRANS, 32'h2);
    chk("e3_hready_m1", HREADY_M1, 32'd0);
    step();
    #1;
    chk("e4_hmaster", HMASTER, 32'd1);
    chk("e4_haddr", HADDR, 32'h00000044);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
